// File: rtl/ac_pkg.sv
// Shared definitions for the common-bus accumulator: micro-op codes and
// rotate-sequencer state encodings.
package ac_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_CMA  = 4'd7;
  localparam logic [3:0] OP_CLE  = 4'd8;
  localparam logic [3:0] OP_CME  = 4'd9;
  localparam logic [3:0] OP_CIR  = 4'd10;
  localparam logic [3:0] OP_CIL  = 4'd11;
  localparam logic [3:0] OP_ROTN = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } rot_state_e;

endpackage

// File: rtl/ac_rot_seq.sv
// Rotate-by-N sequencer: a two-state FSM with a down-counter that tells the
// accumulator datapath when to perform one rotate-right-through-E step.
// The first step happens on the accept edge itself, so AMT steps take AMT
// edges in total.
module ac_rot_seq
  import ac_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] amt_i,
  output logic             step_o,
  output logic             busy_o,
  output logic             done_o
);

  rot_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             step_s;

  // Next-state, counter and step-strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (amt_i == {CNT_W{1'b0}}) begin
            // Zero-length rotate: nothing moves, but the caller still gets DONE.
            done_d = 1'b1;
          end else begin
            step_s = 1'b1;
            cnt_d  = amt_i - CNT_W'(1);
            if (amt_i == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_ROT;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROT: begin
        step_s = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ROT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, counter and DONE pulse; all updates on the falling edge.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign step_o = step_s;
  assign busy_o = (state_q == ST_ROT);
  assign done_o = done_q;

endmodule

// File: rtl/ac_alu_reg.sv
// Accumulator AC with extend flag E for the common-bus datapath. Executes
// single-cycle micro-ops on accept and multi-cycle rotate-by-N through the
// ac_rot_seq sequencer. State updates on the falling edge of CLK.
module ac_alu_reg
  import ac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [3:0]       OP,
  input  logic             OP_VALID,
  output logic             OP_READY,
  input  logic [WIDTH-1:0] AC_INP,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] AC_OUT,
  output logic             E_OUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d;
  logic             busy_s;
  logic             step_s;
  logic             done_s;
  logic             accept_s;
  logic             start_s;
  logic [WIDTH:0]   sum_s;

  // Ops are only taken while no rotate is running; anything else is dropped.
  assign accept_s = OP_VALID & ~busy_s;
  assign start_s  = accept_s & (OP == OP_ROTN);
  assign sum_s    = {1'b0, ac_q} + {1'b0, AC_INP};

  ac_rot_seq #(
    .CNT_W (CNT_W)
  ) u_rot_seq (
    .clk_i   (CLK),
    .rst_ni  (reset_n),
    .start_i (start_s),
    .amt_i   (AMT),
    .step_o  (step_s),
    .busy_o  (busy_s),
    .done_o  (done_s)
  );

  // Micro-op datapath; a sequencer step overrides everything with one CIR.
  always_comb begin
    ac_d = ac_q;
    e_d  = e_q;
    if (step_s) begin
      ac_d = {e_q, ac_q[WIDTH-1:1]};
      e_d  = ac_q[0];
    end else if (accept_s) begin
      case (OP)
        OP_CLR: ac_d = {WIDTH{1'b0}};
        OP_LD:  ac_d = AC_INP;
        OP_INC: ac_d = ac_q + WIDTH'(1);
        OP_DEC: ac_d = ac_q - WIDTH'(1);
        OP_AND: ac_d = ac_q & AC_INP;
        OP_ADD: begin
          ac_d = sum_s[WIDTH-1:0];
          e_d  = sum_s[WIDTH];
        end
        OP_CMA: ac_d = ~ac_q;
        OP_CLE: e_d  = 1'b0;
        OP_CME: e_d  = ~e_q;
        OP_CIR: begin
          ac_d = {e_q, ac_q[WIDTH-1:1]};
          e_d  = ac_q[0];
        end
        OP_CIL: begin
          ac_d = {ac_q[WIDTH-2:0], e_q};
          e_d  = ac_q[WIDTH-1];
        end
        default: begin
          // NOP, zero-length ROTN and reserved codes hold AC and E.
          ac_d = ac_q;
          e_d  = e_q;
        end
      endcase
    end else begin
      ac_d = ac_q;
      e_d  = e_q;
    end
  end

  // Accumulator and extend-flag registers.
  always_ff @(negedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ac_q <= {WIDTH{1'b0}};
      e_q  <= 1'b0;
    end else begin
      ac_q <= ac_d;
      e_q  <= e_d;
    end
  end

  assign AC_OUT   = ac_q;
  assign E_OUT    = e_q;
  assign ZERO     = (ac_q == {WIDTH{1'b0}});
  assign NEG      = ac_q[WIDTH-1];
  assign BUSY     = busy_s;
  assign OP_READY = ~busy_s;
  assign DONE     = done_s;

endmodule
